// File: rtl/mjpg_pkg.sv
// ---------------------------------------------------------------------------
// mjpg_pkg: JPEG marker constants, frame-packer state encoding, lane helpers.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mjpg_pkg;

  localparam int CNT_W_DEF = 24;

  localparam logic [7:0] M_FF  = 8'hFF;
  localparam logic [7:0] M_SOI = 8'hD8;
  localparam logic [7:0] M_EOI = 8'hD9;

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    HFF   = 3'd1,
    FRAME = 3'd2,
    FFF   = 3'd3,
    CLOSE = 3'd4
  } state_t;

  // Byte-lane keep mask for a word holding n bytes (1..4).
  function automatic logic [3:0] keep_of(input logic [2:0] n);
    case (n)
      3'd1:    keep_of = 4'b0001;
      3'd2:    keep_of = 4'b0011;
      3'd3:    keep_of = 4'b0111;
      default: keep_of = 4'b1111;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mjpg_word_pack.sv
// ---------------------------------------------------------------------------
// mjpg_word_pack: byte-lane accumulator feeding one valid/ready output word.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mjpg_word_pack
  import mjpg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  input  logic        i_close,
  input  logic        i_last,
  input  logic        i_soi,
  input  logic        i_trl_push,
  input  logic [31:0] i_trl_word,
  output logic        o_can_acc,
  output logic        o_empty,
  output logic        o_m_valid,
  input  logic        i_m_ready,
  output logic [31:0] o_m_data,
  output logic [3:0]  o_m_keep,
  output logic        o_m_last
);

  logic [31:0] r_acc;
  logic [2:0]  r_cnt;
  logic        r_pend;
  logic        r_last;
  logic        r_valid;
  logic [31:0] r_data;
  logic [3:0]  r_keep;
  logic        r_olast;

  logic        w_out_free;
  logic        w_xfer;
  logic        w_done;
  logic        w_load;
  logic [31:0] w_acc;
  logic [2:0]  w_cnt;
  logic        w_last;

  // A completed word either goes straight to the output register or waits in
  // the accumulator (r_pend) until the output register frees up.
  always_comb begin
    w_out_free = !r_valid || i_m_ready;
    w_xfer     = r_pend && w_out_free;
    w_acc      = w_xfer ? 32'h0 : r_acc;
    w_cnt      = w_xfer ? 3'd0 : r_cnt;
    w_last     = w_xfer ? 1'b0 : r_last;
    w_done     = 1'b0;
    if (i_soi) begin
      w_acc = {16'h0, M_SOI, M_FF};
      w_cnt = 3'd2;
    end
    if (i_push) begin
      case (w_cnt[1:0])
        2'd0:    w_acc[7:0]   = i_byte;
        2'd1:    w_acc[15:8]  = i_byte;
        2'd2:    w_acc[23:16] = i_byte;
        default: w_acc[31:24] = i_byte;
      endcase
      w_cnt  = w_cnt + 3'd1;
      w_last = i_last;
      w_done = (w_cnt == 3'd4) || i_close;
    end
    w_load = w_done && w_out_free && !w_xfer;
  end

  assign o_can_acc = !r_pend || w_out_free;
  assign o_empty   = (r_cnt == 3'd0);
  assign o_m_valid = r_valid;
  assign o_m_data  = r_data;
  assign o_m_keep  = r_keep;
  assign o_m_last  = r_olast;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc   <= 32'h0;
      r_cnt   <= 3'd0;
      r_pend  <= 1'b0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= 32'h0;
      r_keep  <= 4'h0;
      r_olast <= 1'b0;
    end else begin
      if (w_load) begin
        r_acc  <= 32'h0;
        r_cnt  <= 3'd0;
        r_last <= 1'b0;
        r_pend <= 1'b0;
      end else begin
        r_acc  <= w_acc;
        r_cnt  <= w_cnt;
        r_last <= w_last;
        r_pend <= (r_pend && !w_xfer) || w_done;
      end

      if (w_xfer) begin
        r_valid <= 1'b1;
        r_data  <= r_acc;
        r_keep  <= keep_of(r_cnt);
        r_olast <= r_last;
      end else if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_acc;
        r_keep  <= keep_of(w_cnt);
        r_olast <= w_last;
      end else if (i_trl_push) begin
        r_valid <= 1'b1;
        r_data  <= i_trl_word;
        r_keep  <= 4'hF;
        r_olast <= 1'b1;
      end else if (w_out_free) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mjpg_frame_packer.sv
// ---------------------------------------------------------------------------
// mjpg_frame_packer: SOI/EOI frame delimiter packing bytes into 32-bit words.
// Optional per-frame trailer word: define MJPG_PACKER_TRAILER_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mjpg_frame_packer
  import mjpg_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MAX_BYTES = 2**20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cap_en,
  input  logic        in_ready,
  output logic        in_deq,
  input  logic [7:0]  in_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic [3:0]  m_keep,
  output logic        m_last,
  output logic        frame_done,
  output logic        overflow,
  output logic        busy
);

  localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_BYTES);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;

  logic             w_can_acc;
  logic             w_empty;
  logic             w_in_frame;
  logic             w_take;
  logic             w_push;
  logic             w_soi;
  logic             w_is_eoi;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_limit;
  logic             w_close;
  logic             w_word_last;
  logic             w_hshk_last;
  logic             w_close_go;
  logic             w_trl_push;
  logic [31:0]      w_trl_word;

  // r_run keeps intake closed in the first cycle after reset release.
  assign w_in_frame  = (r_state == FRAME) || (r_state == FFF);
  assign in_deq      = r_run && in_ready &&
                       ((r_state == HUNT) || (r_state == HFF) || (w_in_frame && w_can_acc));
  assign w_take      = in_ready && in_deq;
  assign w_push      = w_take && w_in_frame;
  assign w_soi       = w_take && (r_state == HFF) && (in_data == M_SOI) && cap_en;
  assign w_is_eoi    = (r_state == FFF) && (in_data == M_EOI);
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_limit     = (w_cnt_inc == c_MAX_CNT);
  assign w_close     = w_is_eoi || w_limit;
  assign w_hshk_last = m_valid && m_ready && m_last;

`ifdef MJPG_PACKER_TRAILER_EN
  logic [7:0]  r_frm_cnt;
  logic [23:0] w_cnt24;

  assign w_cnt24     = 24'(r_cnt);
  assign w_word_last = 1'b0;
  assign w_trl_push  = (r_state == CLOSE) && w_empty && (!m_valid || m_ready);
  assign w_trl_word  = {r_frm_cnt, w_cnt24};
  assign w_close_go  = w_trl_push;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frm_cnt <= 8'h0;
    end else if (w_trl_push) begin
      r_frm_cnt <= r_frm_cnt + 8'h1;
    end
  end
`else
  assign w_word_last = w_close;
  assign w_trl_push  = 1'b0;
  assign w_trl_word  = 32'h0;
  assign w_close_go  = w_empty;
`endif

  mjpg_word_pack u_pack (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_byte     (in_data),
    .i_close    (w_close),
    .i_last     (w_word_last),
    .i_soi      (w_soi),
    .i_trl_push (w_trl_push),
    .i_trl_word (w_trl_word),
    .o_can_acc  (w_can_acc),
    .o_empty    (w_empty),
    .o_m_valid  (m_valid),
    .i_m_ready  (m_ready),
    .o_m_data   (m_data),
    .o_m_keep   (m_keep),
    .o_m_last   (m_last)
  );

  assign frame_done = r_done;
  assign overflow   = r_ovf;
  assign busy       = r_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= HUNT;
      r_cnt   <= '0;
      r_run   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_run  <= 1'b1;
      r_done <= w_hshk_last;
      r_ovf  <= 1'b0;
      if (w_soi) begin
        r_busy <= 1'b1;
      end else if (w_hshk_last) begin
        r_busy <= 1'b0;
      end
      case (r_state)
        HUNT: begin
          if (w_take && (in_data == M_FF)) r_state <= HFF;
        end
        HFF: begin
          if (w_take) begin
            if (in_data == M_FF) begin
              r_state <= HFF;
            end else if (w_soi) begin
              r_state <= FRAME;
              r_cnt   <= CNT_W'(2);
            end else begin
              r_state <= HUNT;
            end
          end
        end
        FRAME, FFF: begin
          // Limit byte without EOI closes the frame as an overflow.
          if (w_push) begin
            r_cnt <= w_cnt_inc;
            if (w_close) begin
              r_state <= CLOSE;
              r_ovf   <= !w_is_eoi;
            end else if (in_data == M_FF) begin
              r_state <= FFF;
            end else begin
              r_state <= FRAME;
            end
          end
        end
        CLOSE: begin
          if (w_close_go) r_state <= HUNT;
        end
        default: r_state <= HUNT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mjpg_frame_packer.sv
// ---------------------------------------------------------------------------
// tb_mjpg_frame_packer: self-checking bench with a frame-level reference model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mjpg_frame_packer;

  localparam int MAXB = 16;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cap_en = 1'b0;
  logic        in_ready = 1'b0;
  logic        in_deq;
  logic [7:0]  in_data = 8'h00;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        frame_done;
  logic        overflow;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] tx_bytes[$];
  bit         tx_cap[$];
  logic [7:0] frm[$];
  word_t      exp_q[$];
  word_t      got_q[$];
  int         exp_done, exp_ovf, got_done, got_ovf;
  logic       stall_deq, stall_valid, stall_busy;

  mjpg_frame_packer #(.CNT_W(24), .MAX_BYTES(MAXB)) dut (
    .clk        (clk),
    .rst        (rst),
    .cap_en     (cap_en),
    .in_ready   (in_ready),
    .in_deq     (in_deq),
    .in_data    (in_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_last     (m_last),
    .frame_done (frame_done),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: split the byte stream into frames, then cut each frame
  // into 4-byte words with the last word flagged.
  function automatic void pack_frame();
    word_t w;
    for (int k = 0; k < frm.size(); k += 4) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        if (k + j < frm.size()) begin
          w.d[8*j +: 8] = frm[k+j];
          w.k[j] = 1'b1;
        end
      end
      w.l = (k + 4 >= frm.size());
      exp_q.push_back(w);
    end
  endfunction

  function automatic void model();
    logic [7:0] b;
    bit in_fr, prev_ff, eoi;
    in_fr = 0; prev_ff = 0;
    exp_q.delete(); exp_done = 0; exp_ovf = 0;
    foreach (tx_bytes[i]) begin
      b = tx_bytes[i];
      if (!in_fr) begin
        if (prev_ff && b == 8'hD8 && tx_cap[i]) begin
          in_fr = 1; prev_ff = 0;
          frm.delete(); frm.push_back(8'hFF); frm.push_back(8'hD8);
        end else begin
          prev_ff = (b == 8'hFF);
        end
      end else begin
        frm.push_back(b);
        eoi = (b == 8'hD9) && (frm[frm.size()-2] == 8'hFF);
        if (eoi || frm.size() == MAXB) begin
          if (!eoi) exp_ovf++;
          pack_frame();
          exp_done++;
          in_fr = 0; prev_ff = 0;
        end
      end
    end
  endfunction

  task automatic push_bytes(input logic [7:0] b[$], input bit cap);
    foreach (b[i]) begin
      tx_bytes.push_back(b[i]);
      tx_cap.push_back(cap);
    end
  endtask

  task automatic gen_frames(input int n);
    int junk, len;
    for (int f = 0; f < n; f++) begin
      junk = $urandom_range(0, 3);
      for (int j = 0; j < junk; j++) begin
        tx_bytes.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
        tx_cap.push_back(1'($urandom));
      end
      tx_bytes.push_back(8'hFF); tx_cap.push_back(1'($urandom));
      tx_bytes.push_back(8'hD8); tx_cap.push_back($urandom_range(0, 3) != 0);
      len = $urandom_range(0, 20);
      for (int j = 0; j < len; j++) begin
        tx_bytes.push_back(($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom));
        tx_cap.push_back(1'($urandom));
      end
      tx_bytes.push_back(8'hFF); tx_cap.push_back(1'($urandom));
      tx_bytes.push_back(8'hD9); tx_cap.push_back(1'($urandom));
    end
  endtask

  // Drives tx_bytes through the pop interface and records every output word.
  task automatic run_traffic(input int rdy_pct, input int in_pct,
                             input int stall_at, input int stall_len);
    int idx, idle;
    idx = 0; idle = 0;
    got_q.delete(); got_done = 0; got_ovf = 0;
    for (int cyc = 0; cyc < 4000 && idle < 10; cyc++) begin
      @(posedge clk); #1;
      if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + stall_len) begin
        m_ready  = 1'b0;
        in_ready = (idx < tx_bytes.size());
      end else begin
        m_ready  = ($urandom_range(0, 99) < rdy_pct);
        in_ready = (idx < tx_bytes.size()) && ($urandom_range(0, 99) < in_pct);
      end
      in_data = (idx < tx_bytes.size()) ? tx_bytes[idx] : 8'($urandom);
      cap_en  = (idx < tx_bytes.size()) ? tx_cap[idx] : 1'b0;
      @(negedge clk);
      if (cyc == stall_at + stall_len - 1) begin
        stall_deq = in_deq; stall_valid = m_valid; stall_busy = busy;
      end
      if (in_ready && in_deq) idx++;
      if (m_valid && m_ready) got_q.push_back(word_t'({m_data, m_keep, m_last}));
      if (frame_done) got_done++;
      if (overflow) got_ovf++;
      if (idx == tx_bytes.size() && got_q.size() >= exp_q.size()) idle++;
    end
    @(posedge clk); #1;
    in_ready = 1'b0; m_ready = 1'b1;
    checks++;
    if (idle < 10) begin
      errors++;
      $display("FAIL traffic_timeout: consumed %0d of %0d bytes, got %0d of %0d words",
               idx, tx_bytes.size(), got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_ready = 1'b1; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({m_valid, m_keep, m_last, frame_done, overflow, busy, in_deq} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got v=%b k=%h l=%b fd=%b ov=%b busy=%b deq=%b, want all 0",
               m_valid, m_keep, m_last, frame_done, overflow, busy, in_deq);
    end
    checks++;
    if (m_data !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h want 00000000", m_data);
    end
    @(posedge clk); #1;
    rst = 1'b1; in_ready = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    tx_bytes.delete(); tx_cap.delete();
    push_bytes('{8'h00, 8'h11, 8'hFF, 8'hD8, 8'hAA, 8'hBB, 8'hFF, 8'hD9}, 1'b1);
    model();
    run_traffic(100, 100, -1, 0);
    checks++;
    if (got_q.size() !== 2) begin
      errors++; $display("FAIL basic_count: got %0d words want 2", got_q.size());
    end
    checks++;
    if (got_q[0] !== word_t'({32'hBBAAD8FF, 4'hF, 1'b0})) begin
      errors++; $display("FAIL basic_w0: got %h/%h/%b want BBAAD8FF/f/0", got_q[0].d, got_q[0].k, got_q[0].l);
    end
    checks++;
    if (got_q[1] !== word_t'({32'h0000D9FF, 4'h3, 1'b1})) begin
      errors++; $display("FAIL basic_w1: got %h/%h/%b want 0000D9FF/3/1", got_q[1].d, got_q[1].k, got_q[1].l);
    end
    checks++;
    if (got_done !== 1 || got_ovf !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_flags: done=%0d ovf=%0d busy=%b want 1 0 0", got_done, got_ovf, busy);
    end
  endtask

  task automatic test_stuffing();
    tx_bytes.delete(); tx_cap.delete();
    push_bytes('{8'hFF, 8'hD8, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hD9, 8'h12}, 1'b1);
    model();
    run_traffic(100, 100, -1, 0);
    checks++;
    if (got_q.size() !== 2) begin
      errors++; $display("FAIL stuff_count: got %0d words want 2", got_q.size());
    end
    checks++;
    if (got_q[0] !== word_t'({32'h00FFD8FF, 4'hF, 1'b0})) begin
      errors++; $display("FAIL stuff_w0: got %h/%h/%b want 00FFD8FF/f/0", got_q[0].d, got_q[0].k, got_q[0].l);
    end
    checks++;
    if (got_q[1] !== word_t'({32'h00D9FFFF, 4'h7, 1'b1})) begin
      errors++; $display("FAIL stuff_w1: got %h/%h/%b want 00D9FFFF/7/1", got_q[1].d, got_q[1].k, got_q[1].l);
    end
  endtask

  task automatic test_stall();
    tx_bytes.delete(); tx_cap.delete();
    push_bytes('{8'hFF, 8'hD8}, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tx_bytes.push_back(8'(8'h40 + i)); tx_cap.push_back(1'b1);
    end
    push_bytes('{8'hFF, 8'hD9}, 1'b1);
    model();
    run_traffic(100, 100, 4, 20);
    checks++;
    if ({stall_deq, stall_valid, stall_busy} !== 3'b011) begin
      errors++; $display("FAIL stall_hold: deq=%b valid=%b busy=%b want 0 1 1", stall_deq, stall_valid, stall_busy);
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL stall_count: got %0d words want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL stall_word%0d: got %h/%h/%b want %h/%h/%b", i,
                           got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
      end
    end
  endtask

  task automatic test_cap_en();
    tx_bytes.delete(); tx_cap.delete();
    push_bytes('{8'hFF}, 1'b1);
    push_bytes('{8'hD8}, 1'b0);
    push_bytes('{8'h20, 8'h27, 8'hFF, 8'hD9}, 1'b1);
    push_bytes('{8'hFF, 8'hD8, 8'h31}, 1'b1);
    push_bytes('{8'hFF, 8'hD9}, 1'b0);
    model();
    run_traffic(100, 100, -1, 0);
    checks++;
    if (got_q.size() !== 2 || got_done !== 1) begin
      errors++; $display("FAIL cap_count: got %0d words %0d frames want 2 1", got_q.size(), got_done);
    end
    checks++;
    if (got_q[0].d !== 32'hFF31D8FF) begin
      errors++; $display("FAIL cap_w0: got %h want FF31D8FF", got_q[0].d);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL cap_word%0d: got %h/%h/%b want %h/%h/%b", i,
                           got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
      end
    end
  endtask

  task automatic test_overflow();
    tx_bytes.delete(); tx_cap.delete();
    push_bytes('{8'hFF, 8'hD8}, 1'b1);
    for (int i = 0; i < 38; i++) begin
      tx_bytes.push_back(8'(i + 1)); tx_cap.push_back(1'b1);
    end
    push_bytes('{8'hFF, 8'hD8, 8'h55, 8'hFF, 8'hD9}, 1'b1);
    model();
    run_traffic(80, 90, -1, 0);
    checks++;
    if (got_ovf !== 1 || got_done !== 2) begin
      errors++; $display("FAIL ovf_pulses: ovf=%0d done=%0d want 1 2", got_ovf, got_done);
    end
    checks++;
    if (got_q[3].l !== 1'b1 || got_q[2].l !== 1'b0 || got_q[3].d !== 32'h0E0D0C0B) begin
      errors++; $display("FAIL ovf_cut: w2.last=%b w3.last=%b w3=%h want 0 1 0E0D0C0B",
                         got_q[2].l, got_q[3].l, got_q[3].d);
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL ovf_count: got %0d words want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ovf_word%0d: got %h/%h/%b want %h/%h/%b", i,
                           got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] part[$];
    int idx;
    part = '{8'hFF, 8'hD8, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    idx = 0;
    for (int cyc = 0; cyc < 50 && idx < part.size(); cyc++) begin
      @(posedge clk); #1;
      m_ready = 1'b0; in_ready = 1'b1; cap_en = 1'b1; in_data = part[idx];
      @(negedge clk);
      if (in_ready && in_deq) idx++;
    end
    @(posedge clk); #1;
    in_ready = 1'b0;
    checks++;
    if (idx !== 6 || busy !== 1'b1 || m_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: bytes=%0d busy=%b valid=%b want 6 1 1", idx, busy, m_valid);
    end
    rst = 1'b0; in_ready = 1'b1;
    #1;
    checks++;
    if ({m_valid, m_data, m_keep, m_last, frame_done, overflow, busy, in_deq} !== 42'b0) begin
      errors++; $display("FAIL rstmid_zero: v=%b d=%h k=%h busy=%b deq=%b want all 0",
                         m_valid, m_data, m_keep, busy, in_deq);
    end
    @(posedge clk); #1;
    rst = 1'b1; in_ready = 1'b0;
    tx_bytes.delete(); tx_cap.delete();
    push_bytes('{8'hA5, 8'hA6, 8'hFF, 8'hD8, 8'hB1, 8'hFF, 8'hD9}, 1'b1);
    model();
    run_traffic(100, 100, -1, 0);
    checks++;
    if (got_q.size() !== 2 || got_q[0].d !== 32'hFFB1D8FF || got_q[1] !== exp_q[1]) begin
      errors++; $display("FAIL rstmid_next: got %0d words w0=%h w1=%h want 2 FFB1D8FF %h",
                         got_q.size(), got_q[0].d, got_q[1].d, exp_q[1].d);
    end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 6; it++) begin
      tx_bytes.delete(); tx_cap.delete();
      gen_frames(4);
      model();
      run_traffic($urandom_range(30, 100), $urandom_range(50, 100), -1, 0);
      checks++;
      if (got_q.size() !== exp_q.size() || got_done !== exp_done || got_ovf !== exp_ovf) begin
        errors++; $display("FAIL b2b%0d_count: words %0d/%0d done %0d/%0d ovf %0d/%0d (got/want)", it,
                           got_q.size(), exp_q.size(), got_done, exp_done, got_ovf, exp_ovf);
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL b2b%0d_word%0d: got %h/%h/%b want %h/%h/%b", it, i,
                             got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuffing();
    test_stall();
    test_cap_en();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
